// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling-lane result collector.
package pool_pkg;

  localparam int POOL_NUM_DEF   = 16;
  localparam int DATA_WIDTH_DEF = 8;

  // Collector layer state: armed by start, finished by lane 0's last word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_e;

  // One skew-FIFO entry as produced by a pooling lane.
  typedef struct packed {
    logic                      last;
    logic [DATA_WIDTH_DEF-1:0] data;
  } lane_entry_t;

endpackage

// File: rtl/pool_lane_fifo.sv
// Per-lane skew FIFO: registered storage, flush, same-cycle push/pop.
module pool_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; flush discards everything including same-cycle traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is never read outside the valid window, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pool_collector.sv
// Collects one result per pooling lane, packs them, writes the output buffer.
module pool_collector
  import pool_pkg::*;
#(
  parameter int POOL_NUM   = POOL_NUM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [POOL_NUM-1:0]                  pool_last_i,
  input  logic [POOL_NUM-1:0]                  pool_valid_i,
  input  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]  pool_result_i,
  output logic                                 buf_wr_en_o,
  output logic [ADDR_WIDTH-1:0]                buf_wr_addr_o,
  output logic [POOL_NUM*DATA_WIDTH-1:0]       buf_wr_data_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 ovf_o,
  output logic                                 last_err_o
);

  pool_state_e state, state_nxt;

  logic                                arm;
  logic                                run;
  logic                                pop_all;
  logic                                ovf_hit;
  logic                                last_mis;
  logic [POOL_NUM-1:0]                 push;
  logic [POOL_NUM-1:0]                 full;
  logic [POOL_NUM-1:0]                 empty;
  logic [POOL_NUM-1:0]                 last_pop;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0] data_pop;
  logic [POOL_NUM-1:0][DATA_WIDTH:0]   rd;
  logic [ADDR_WIDTH-1:0]               addr;

  assign arm      = (state == IDLE) && start_i;
  assign run      = (state == RUN);
  assign push     = pool_valid_i & {POOL_NUM{run}};
  // A word is complete only when every lane has something to contribute.
  assign pop_all  = run && !(|empty);
  assign ovf_hit  = |(push & full) && !pop_all;
  assign last_mis = |(last_pop ^ {POOL_NUM{last_pop[0]}});
  assign busy_o   = run;

  for (genvar g = 0; g < POOL_NUM; g++) begin : g_lane
    pool_lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (arm),
      .push  (push[g]),
      .pop   (pop_all),
      .wdata ({pool_last_i[g], pool_result_i[g]}),
      .rdata (rd[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
    assign last_pop[g] = rd[g][DATA_WIDTH];
    assign data_pop[g] = rd[g][DATA_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: lane 0 alone decides when the layer ends.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (pop_all && last_pop[0]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port, address counter, done pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_wr_en_o   <= 1'b0;
      buf_wr_addr_o <= '0;
      buf_wr_data_o <= '0;
      addr          <= '0;
      done_o        <= 1'b0;
      ovf_o         <= 1'b0;
      last_err_o    <= 1'b0;
    end else begin
      buf_wr_en_o <= pop_all;
      done_o      <= (state == DONE);
      if (arm) begin
        addr       <= base_addr_i;
        ovf_o      <= 1'b0;
        last_err_o <= 1'b0;
      end else begin
        if (ovf_hit) ovf_o <= 1'b1;
        if (pop_all) begin
          buf_wr_addr_o <= addr;
          buf_wr_data_o <= data_pop;
          addr          <= addr + 1'b1;
          if (last_mis) last_err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_collector.sv
// Self-checking bench for pool_collector: directed table, corner sequences, random layers.
module tb_pool_collector;
  import pool_pkg::*;

  localparam int P     = 16;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [AW-1:0]         base;
  logic [P-1:0]          plast;
  logic [P-1:0]          pvalid;
  logic [P-1:0][DW-1:0]  pres;
  logic                  buf_wr_en_o;
  logic [AW-1:0]         buf_wr_addr_o;
  logic [P*DW-1:0]       buf_wr_data_o;
  logic                  busy_o, done_o, ovf_o, last_err_o;

  pool_collector #(.POOL_NUM(P), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base),
    .pool_last_i(plast), .pool_valid_i(pvalid), .pool_result_i(pres),
    .buf_wr_en_o(buf_wr_en_o), .buf_wr_addr_o(buf_wr_addr_o), .buf_wr_data_o(buf_wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .last_err_o(last_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [P*DW-1:0] data;
  } wr_t;
  wr_t wlog [$];

  typedef struct {
    logic [AW-1:0] base;
    int            beats;
    int            skew;
    bit            early7;
    int            exp_writes;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    int            exp_lat;
    bit            exp_err;
  } vec_t;
  vec_t vecs [4];

  // Reference model: lane queues, a layer flag and the expected outputs.
  lane_entry_t   lq [P][$];
  int            m_state;
  logic [AW-1:0] m_addr, m_waddr;
  logic [P*DW-1:0] m_data;
  logic          m_en, m_busy, m_done, m_ovf, m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) lq[i].delete();
    m_state = 0; m_addr = '0; m_waddr = '0; m_data = '0;
    m_en = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit pop;
    int nst;
    logic [P-1:0] lasts;
    if (!rst) begin
      model_reset();
      return;
    end
    m_done = (m_state == 2);
    nst    = m_state;
    pop    = (m_state == 1);
    lasts  = '0;
    for (int i = 0; i < P; i++) if (lq[i].size() == 0) pop = 0;
    m_en = pop;
    if (pop) begin
      for (int i = 0; i < P; i++) begin
        lane_entry_t e;
        e = lq[i].pop_front();
        lasts[i] = e.last;
        m_data[i*DW +: DW] = e.data;
      end
      m_waddr = m_addr;
      m_addr  = m_addr + 10'd1;
      if (lasts != {P{lasts[0]}}) m_err = 1;
      if (lasts[0]) nst = 2;
    end
    if (m_state == 1) begin
      for (int i = 0; i < P; i++) begin
        if (pvalid[i]) begin
          if (lq[i].size() < DEPTH) lq[i].push_back('{last: plast[i], data: pres[i]});
          else m_ovf = 1;
        end
      end
    end
    if (m_state == 0 && start) begin
      for (int i = 0; i < P; i++) lq[i].delete();
      m_addr = base; m_ovf = 0; m_err = 0; nst = 1;
    end else if (m_state == 2) begin
      nst = 0;
    end
    m_state = nst;
    m_busy  = (nst == 1);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    chk("wr_en", buf_wr_en_o, m_en);
    chk("wr_addr", buf_wr_addr_o, m_waddr);
    chk("wr_data", buf_wr_data_o, m_data);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    chk("ovf", ovf_o, m_ovf);
    chk("last_err", last_err_o, m_err);
    if (buf_wr_en_o) wlog.push_back('{cyc: cyc, addr: buf_wr_addr_o, data: buf_wr_data_o});
    if (done_o) done_cyc = cyc;
  endtask

  task automatic idle_inputs();
    start = 0; base = '0; pvalid = '0; plast = '0; pres = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cyc < 0 && n < 25) begin
      step();
      n++;
    end
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s: done_o not seen within 25 cycles", tag);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w0, t0, n, beat;
    w0 = wlog.size();
    done_cyc = -1;
    start = 1; base = v.base;
    step();
    idle_inputs();
    t0 = cyc;
    for (int c = 0; c < v.beats + v.skew; c++) begin
      for (int i = 0; i < P; i++) begin
        beat = (i == 15) ? c - v.skew : c;
        if (beat >= 0 && beat < v.beats) begin
          pvalid[i] = 1'b1;
          pres[i]   = 8'(3 * beat + i);
          plast[i]  = (i == 7 && v.early7) ? (beat == v.beats - 2) : (beat == v.beats - 1);
        end else begin
          pvalid[i] = 1'b0; pres[i] = '0; plast[i] = 1'b0;
        end
      end
      step();
    end
    idle_inputs();
    wait_done(tag);
    n = wlog.size() - w0;
    chk({tag, "_nwrites"}, n, v.exp_writes);
    if (n > 0) begin
      chk({tag, "_first_addr"}, wlog[w0].addr, v.exp_first);
      chk({tag, "_last_addr"}, wlog[wlog.size()-1].addr, v.exp_last);
      chk({tag, "_latency"}, wlog[w0].cyc - t0, v.exp_lat);
      if (done_cyc >= 0) chk({tag, "_done_gap"}, done_cyc - wlog[wlog.size()-1].cyc, 1);
    end
    if (n > 1) chk({tag, "_w1_lane5"}, wlog[w0+1].data[5*DW +: DW], 8'h08);
    chk({tag, "_err"}, last_err_o, v.exp_err);
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, beats, early;
    int offs [P];
    vec_t vr;

    vecs[0] = '{base: 10'h010, beats: 3, skew: 0, early7: 0, exp_writes: 3,
                exp_first: 10'h010, exp_last: 10'h012, exp_lat: 2, exp_err: 0};
    vecs[1] = '{base: 10'h020, beats: 2, skew: 3, early7: 0, exp_writes: 2,
                exp_first: 10'h020, exp_last: 10'h021, exp_lat: 5, exp_err: 0};
    vecs[2] = '{base: 10'h3FE, beats: 3, skew: 0, early7: 0, exp_writes: 3,
                exp_first: 10'h3FE, exp_last: 10'h000, exp_lat: 2, exp_err: 0};
    vecs[3] = '{base: 10'h100, beats: 3, skew: 0, early7: 1, exp_writes: 3,
                exp_first: 10'h100, exp_last: 10'h102, exp_lat: 2, exp_err: 1};
    vr      = '{base: 10'h200, beats: 1, skew: 0, early7: 0, exp_writes: 1,
                exp_first: 10'h200, exp_last: 10'h200, exp_lat: 2, exp_err: 0};

    rst = 0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_wr_en", buf_wr_en_o, 0);
    chk("rst_wr_addr", buf_wr_addr_o, 0);
    chk("rst_wr_data", buf_wr_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_err", last_err_o, 0);
    @(negedge clk);
    rst = 1;
    step();

    // Directed table: aligned, skewed, wrapping and last-mismatch layers.
    for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Overflow: lane 0 runs ahead by five beats with every other lane silent.
    done_cyc = -1;
    start = 1; base = 10'h040;
    step();
    idle_inputs();
    w0 = wlog.size();
    for (int c = 0; c < 5; c++) begin
      pvalid = 16'h0001; pres[0] = 8'(c); plast[0] = (c >= 3);
      step();
      if (c == 3) chk("ovf_at_depth", ovf_o, 0);
    end
    idle_inputs();
    chk("ovf_after_5", ovf_o, 1);
    chk("ovf_no_writes", wlog.size() - w0, 0);
    for (int c = 0; c < 4; c++) begin
      pvalid = 16'hFFFE;
      for (int i = 1; i < P; i++) pres[i] = 8'(c + i);
      plast = (c == 3) ? 16'hFFFE : 16'h0000;
      step();
    end
    idle_inputs();
    wait_done("ovf_layer");
    chk("ovf_layer_writes", wlog.size() - w0, 4);
    chk("ovf_sticky", ovf_o, 1);
    start = 1; base = 10'h300;
    step();
    idle_inputs();
    chk("ovf_clear", ovf_o, 0);

    // Reset mid-layer after one of three beats.
    w0 = wlog.size();
    pvalid = '1;
    for (int i = 0; i < P; i++) pres[i] = 8'(i + 1);
    step();
    idle_inputs();
    rst = 0;
    #1;
    chk("amid_wr_en", buf_wr_en_o, 0);
    chk("amid_wr_addr", buf_wr_addr_o, 0);
    chk("amid_wr_data", buf_wr_data_o, 0);
    chk("amid_busy", busy_o, 0);
    chk("amid_done", done_o, 0);
    chk("amid_ovf", ovf_o, 0);
    chk("amid_err", last_err_o, 0);
    model_reset();
    step();
    rst = 1;
    for (int c = 0; c < 3; c++) step();
    chk("amid_no_writes", wlog.size() - w0, 0);
    run_vec(vr, "after_rst");

    // Random layers: per-lane skew, stray valids, ignored starts, early lasts.
    for (int l = 0; l < 30; l++) begin
      done_cyc = -1;
      for (int c = 0; c < 2; c++) begin
        pvalid = 16'($urandom); plast = 16'($urandom);
        for (int i = 0; i < P; i++) pres[i] = 8'($urandom);
        step();
      end
      idle_inputs();
      start = 1; base = 10'($urandom);
      step();
      idle_inputs();
      beats = $urandom_range(1, 5);
      early = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
      for (int i = 0; i < P; i++) offs[i] = $urandom_range(0, 3);
      for (int c = 0; c < beats + 3; c++) begin
        start = (c < beats) && ($urandom_range(0, 7) == 0);
        base  = 10'($urandom);
        for (int i = 0; i < P; i++) begin
          int b;
          b = c - offs[i];
          pvalid[i] = (b >= 0 && b < beats);
          pres[i]   = 8'($urandom);
          plast[i]  = (i == early) ? (b == beats - 2) : (b == beats - 1);
          if (!pvalid[i]) plast[i] = 1'b0;
        end
        step();
      end
      idle_inputs();
      wait_done($sformatf("rand%0d", l));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
